// File: rtl/fixed_point_accumulator_pkg.sv
// fixed_point_accumulator_pkg: Q-format constants, default widths and FSM states for the PE accumulator
package fixed_point_accumulator_pkg;
    localparam int DEF_BITSIZE   = 14;
    localparam int DEF_FRAC_BITS = 7;
    localparam int DEF_ACC_BITS  = 20;
    localparam int DEF_CNT_W     = 6;
    localparam logic [DEF_BITSIZE-1:0] Q_MAX = 14'h1FFF;
    localparam logic [DEF_BITSIZE-1:0] Q_MIN = 14'h2000;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/fixed_point_accumulator_sat_narrow.sv
// fixed_point_accumulator_sat_narrow: clamps a wide signed value into a narrower signed Q word, flagging overflow
module fixed_point_accumulator_sat_narrow #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 14
) (
    input  logic [IN_W-1:0]  i_acc,
    output logic [OUT_W-1:0] o_q,
    output logic             o_ovf
);
    logic [IN_W-OUT_W:0] w_top;
    assign w_top = i_acc[IN_W-1:OUT_W-1];
    assign o_ovf = ~(&w_top | ~|w_top);
    assign o_q   = o_ovf ? {i_acc[IN_W-1], {(OUT_W-1){~i_acc[IN_W-1]}}} : i_acc[OUT_W-1:0];
endmodule

// File: rtl/fixed_point_accumulator.sv
// fixed_point_accumulator: sums a programmable window of Q products plus bias, saturating to the Q output format
module fixed_point_accumulator
    import fixed_point_accumulator_pkg::*;
#(
    parameter int bitsize  = DEF_BITSIZE,
    parameter int ACC_BITS = DEF_ACC_BITS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_terms,
    input  logic [bitsize-1:0] bias,
    input  logic [bitsize-1:0] data_in,
    input  logic               valid_in,
    output logic [bitsize-1:0] acc_out,
    output logic               out_valid,
    output logic               busy,
    output logic               sat_flag
);
    state_t               r_state, w_next;
    logic [ACC_BITS-1:0]  r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_sticky;
    logic [bitsize-1:0]   r_acc_out;
    logic                 r_out_valid, r_sat_flag;
    logic [ACC_BITS-1:0]  w_term, w_bias, w_sat;
    logic [ACC_BITS:0]    w_sum;
    logic                 w_add_ovf, w_take, w_narrow_ovf;
    logic [bitsize-1:0]   w_narrow;

    assign w_term    = {{(ACC_BITS-bitsize){data_in[bitsize-1]}}, data_in};
    assign w_bias    = {{(ACC_BITS-bitsize){bias[bitsize-1]}}, bias};
    assign w_sum     = {r_acc[ACC_BITS-1], r_acc} + {w_term[ACC_BITS-1], w_term};
    assign w_add_ovf = w_sum[ACC_BITS] ^ w_sum[ACC_BITS-1];
    assign w_sat     = w_add_ovf ? {w_sum[ACC_BITS], {(ACC_BITS-1){~w_sum[ACC_BITS]}}} : w_sum[ACC_BITS-1:0];
    assign w_take    = (r_state == ACCUM) && valid_in;
    assign busy      = r_state != IDLE;
    assign acc_out   = r_acc_out;
    assign out_valid = r_out_valid;
    assign sat_flag  = r_sat_flag;

    fixed_point_accumulator_sat_narrow #(.IN_W(ACC_BITS), .OUT_W(bitsize)) u_narrow (
        .i_acc(r_acc),
        .o_q  (w_narrow),
        .o_ovf(w_narrow_ovf)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // next state: a zero-term window skips straight to DONE; DONE always lasts one cycle
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) begin
            if (start) w_next = (num_terms == '0) ? DONE : ACCUM;
        end else if (r_state == ACCUM) begin
            if (valid_in && r_cnt == CNT_W'(1)) w_next = DONE;
        end else begin
            w_next = IDLE;
        end
    end

    // datapath: load bias on start, saturating add per valid term, publish narrowed result in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
            r_acc_out   <= '0;
            r_out_valid <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == IDLE && start) begin
                r_acc    <= w_bias;
                r_cnt    <= num_terms;
                r_sticky <= 1'b0;
            end
            if (w_take) begin
                r_acc    <= w_sat;
                r_cnt    <= r_cnt - CNT_W'(1);
                r_sticky <= r_sticky | w_add_ovf;
            end
            if (r_state == DONE) begin
                r_acc_out   <= w_narrow;
                r_out_valid <= 1'b1;
                r_sat_flag  <= r_sticky | w_narrow_ovf;
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_accumulator.sv
// tb_fixed_point_accumulator: randomized and directed checks of the window accumulator against an arithmetic model
module tb_fixed_point_accumulator;
    logic        clk = 0, rst = 0, start = 0, valid_in = 0;
    logic [5:0]  num_terms = 0;
    logic [13:0] bias = 0, data_in = 0;
    logic [13:0] acc_out;
    logic        out_valid, busy, sat_flag;
    int tests = 0, fails = 0;
    int term_q[64];
    int gap_q[64];
    int busy_low;

    fixed_point_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .num_terms(num_terms), .bias(bias),
        .data_in(data_in), .valid_in(valid_in), .acc_out(acc_out), .out_valid(out_valid),
        .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // window result from plain integer arithmetic: 20-bit clamped running sum, then 14-bit clamp
    function automatic void model(input int b, input int n, output int q, output bit f);
        int acc;
        acc = b;
        f = 0;
        for (int i = 0; i < n; i++) begin
            acc = acc + term_q[i];
            if (acc > 524287) begin acc = 524287; f = 1; end
            else if (acc < -524288) begin acc = -524288; f = 1; end
        end
        if (acc > 8191) begin q = 8191; f = 1; end
        else if (acc < -8192) begin q = -8192; f = 1; end
        else q = acc;
    endfunction

    // issues start (with a junk valid beat alongside) and the first m terms; ignored start pulses fill the gaps
    task automatic drive_window(input int b, input int n, input int m);
        busy_low = 0;
        start = 1; num_terms = n[5:0]; bias = b[13:0]; valid_in = 1; data_in = 14'($urandom);
        @(posedge clk); #1;
        start = 0; valid_in = 0;
        for (int i = 0; i < m; i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                if (!busy) busy_low++;
                start = 1; num_terms = 6'($urandom); bias = 14'($urandom); data_in = 14'($urandom);
                @(posedge clk); #1;
                start = 0;
            end
            if (!busy) busy_low++;
            valid_in = 1; data_in = 14'(term_q[i]);
            @(posedge clk); #1;
            valid_in = 0;
        end
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (acc_out !== 14'h0 || out_valid !== 1'b0 || sat_flag !== 1'b0) begin
            fails++; $display("FAIL reset_out: acc_out=%h out_valid=%b sat_flag=%b, want 0/0/0", acc_out, out_valid, sat_flag);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: busy=%b want 0", busy); end
        rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        for (int i = 0; i < 9; i++) begin term_q[i] = 128; gap_q[i] = 0; end
        drive_window(0, 9, 9);
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL basic_done: out_valid=%b busy=%b want 0/1", out_valid, busy); end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== 14'd1152 || sat_flag !== 1'b0) begin
            fails++; $display("FAIL basic_out: v=%b acc=%0d sat=%b want 1/1152/0", out_valid, acc_out, sat_flag);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_pulse: out_valid=%b busy=%b want 0/0", out_valid, busy); end
    endtask

    task automatic test_bias_stalls;
        term_q[0] = 256; term_q[1] = -384; term_q[2] = 64;
        gap_q[0] = 0; gap_q[1] = 2; gap_q[2] = 2;
        drive_window(-64, 3, 3);
        if (!busy) busy_low++;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== 14'h3F80 || sat_flag !== 1'b0) begin
            fails++; $display("FAIL bias_out: v=%b acc=%h sat=%b want 1/3f80/0", out_valid, acc_out, sat_flag);
        end
        tests++;
        if (busy_low != 0) begin fails++; $display("FAIL bias_busy: busy low for %0d cycles want 0", busy_low); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation;
        int v;
        logic [13:0] e;
        for (int k = 0; k < 2; k++) begin
            v = (k == 0) ? 8191 : -8192;
            e = (k == 0) ? 14'h1FFF : 14'h2000;
            for (int i = 0; i < 4; i++) begin term_q[i] = v; gap_q[i] = 0; end
            drive_window(0, 4, 4);
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || acc_out !== e || sat_flag !== 1'b1) begin
                fails++; $display("FAIL sat_%0d: v=%b acc=%h sat=%b want 1/%h/1", k, out_valid, acc_out, sat_flag, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_terms;
        drive_window(300, 0, 0);
        tests++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL zero_done: busy=%b v=%b want 1/0", busy, out_valid); end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== 14'd300 || sat_flag !== 1'b0) begin
            fails++; $display("FAIL zero_out: v=%b acc=%0d sat=%b want 1/300/0", out_valid, acc_out, sat_flag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored;
        valid_in = 1; data_in = 14'd500;
        repeat (3) @(posedge clk);
        #1;
        valid_in = 0;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: busy=%b v=%b want 0/0", busy, out_valid); end
        term_q[0] = 100; term_q[1] = 200; term_q[2] = -50;
        gap_q[0] = 1; gap_q[1] = 1; gap_q[2] = 1;
        drive_window(0, 3, 3);
        start = 1; valid_in = 1; num_terms = 6'd5; data_in = 14'd77;
        @(posedge clk); #1;
        start = 0; valid_in = 0;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== 14'd250 || busy !== 1'b0) begin
            fails++; $display("FAIL ignored_out: v=%b acc=%0d busy=%b want 1/250/0", out_valid, acc_out, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 9; i++) begin term_q[i] = 128; gap_q[i] = 0; end
        drive_window(0, 9, 4);
        rst = 0;
        #1;
        tests++;
        if (acc_out !== 14'h0 || out_valid !== 1'b0 || busy !== 1'b0 || sat_flag !== 1'b0) begin
            fails++; $display("FAIL midrst: acc=%h v=%b busy=%b sat=%b want 0/0/0/0", acc_out, out_valid, busy, sat_flag);
        end
        #1 rst = 1;
        @(posedge clk); #1;
        drive_window(10, 9, 9);
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== 14'd1162) begin
            fails++; $display("FAIL midrst_next: v=%b acc=%0d want 1/1162", out_valid, acc_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_integration;
        int a, b;
        a = 128; b = 64;
        for (int i = 0; i < 9; i++) begin term_q[i] = (a * b) >>> 7; gap_q[i] = 0; end
        drive_window(0, 9, 9);
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== 14'd576) begin
            fails++; $display("FAIL mult_chain: v=%b acc=%0d want 1/576", out_valid, acc_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int b, n, q;
        bit f;
        logic [13:0] e;
        for (int w = 0; w < 4; w++) begin
            n = $urandom_range(1, 10);
            b = int'($urandom_range(0, 2047)) - 1024;
            for (int i = 0; i < n; i++) begin term_q[i] = int'($urandom_range(0, 4095)) - 2048; gap_q[i] = 0; end
            model(b, n, q, f);
            e = 14'(q);
            drive_window(b, n, n);
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || acc_out !== e || sat_flag !== f) begin
                fails++; $display("FAIL b2b_%0d: v=%b acc=%h sat=%b want 1/%h/%b", w, out_valid, acc_out, sat_flag, e, f);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int b, n, q;
        bit f;
        logic [13:0] e;
        for (int w = 0; w < 30; w++) begin
            n = (w == 0) ? 63 : $urandom_range(1, 20);
            b = int'($urandom_range(0, 16383)) - 8192;
            for (int i = 0; i < n; i++) begin
                term_q[i] = (w % 3 == 0) ? ((i % 2 == 0) ? 8191 : int'($urandom_range(4000, 8191)))
                                         : int'($urandom_range(0, 16383)) - 8192;
                if (w == 0) term_q[i] = -8192;
                gap_q[i] = $urandom_range(0, 2);
            end
            model(b, n, q, f);
            e = 14'(q);
            drive_window(b, n, n);
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || acc_out !== e || sat_flag !== f) begin
                fails++; $display("FAIL rand_%0d: n=%0d v=%b acc=%h sat=%b want 1/%h/%b", w, n, out_valid, acc_out, sat_flag, e, f);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_bias_stalls;
        test_saturation;
        test_zero_terms;
        test_ignored;
        test_reset_mid;
        test_integration;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fixed_point_accumulator.md
Name: fixed_point_accumulator

Overview:
- Downstream stage of the fixed-point multiplier in the MobileNetV3 PE datapath.
- Consumes the multiplier's registered product stream (Mul_result, valid) and sums a programmable number of products, for example 9 taps for a 3x3 depthwise window or C_in terms for a pointwise channel sum.
- Adds a bias, saturates the sum to the signed Q format, and emits one result with a one-cycle valid pulse per window.

Parameters:
- bitsize, 14, total width of products, bias and result (signed).
- FRAC_BITS, 7, fractional bits; products and bias share this Q format, so no realignment is done.
- ACC_BITS, 20, internal accumulator width (bitsize + 6 guard bits).
- CNT_W, 6, width of the term counter; maximum window is 2^CNT_W-1 = 63 terms.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new window. Honoured only in IDLE.
- num_terms  input  CNT_W  number of products in the window; sampled on start.
- bias  input  bitsize  signed Q bias; sampled on start.
- data_in  input  bitsize  signed product (multiplier Mul_result).
- valid_in  input  1  data_in qualifier (multiplier valid).
- acc_out  output  bitsize  saturated window result, registered.
- out_valid  output  1  one-cycle pulse when acc_out is new.
- busy  output  1  high in ACCUM and DONE.
- sat_flag  output  1  registered with out_valid; 1 if internal or output saturation occurred in this window.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc=0, cnt=0, acc_out=0, out_valid=0, sat_flag=0, busy=0.
- States are IDLE, ACCUM and DONE.
- IDLE:
  - On start=1: acc <= sign-extended bias; cnt <= num_terms; internal sticky sat <= 0.
  - If num_terms==0, go to DONE; otherwise go to ACCUM.
  - valid_in in IDLE is dropped.
- ACCUM:
  - On each cycle with valid_in=1: acc <= sat_add(acc, sign-extended data_in); cnt <= cnt-1.
  - When cnt==1 and valid_in=1, go to DONE.
  - valid_in=0 stalls; there is no timeout.
  - start is ignored.
- DONE (exactly one cycle):
  - acc_out <= narrow(acc); out_valid <= 1; sat_flag <= sticky | narrow_overflow; go to IDLE.
  - valid_in and start are ignored.
- out_valid is 1 only in the cycle after DONE. At all other times out_valid=0 and acc_out holds its last value.
- Latency: the last term is added at edge k; out_valid and acc_out are visible after edge k+1. A new start is accepted at edge k+2 or later.
- Back-to-back windows cost 2 idle cycles of overhead (DONE plus IDLE start).
- sat_add:
  - Computes a full ACC_BITS+1 sum.
  - On overflow it clamps to +(2^(ACC_BITS-1)-1) or -2^(ACC_BITS-1) and sets the sticky bit.
  - Once clamped, later terms continue to add normally.
- narrow:
  - If acc > 2^(bitsize-1)-1, output 0x1FFF and flag.
  - If acc < -2^(bitsize-1), output 0x2000 and flag.
  - Otherwise output acc[bitsize-1:0].
- No rounding is needed; the Q format is unchanged.
- Mid-operation reset: returns immediately to the reset values and the partial window is discarded.
- Simultaneous start and valid_in in IDLE: the start is taken and that data_in is NOT counted. The upstream must present its first product one cycle after start or later.

Decomposition:
- Shared package/header holds:
  - Q-format constants: bitsize, FRAC_BITS, Q_MAX=0x1FFF, Q_MIN=0x2000.
  - ACC_BITS and CNT_W defaults.
  - State encodings: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
- One combinational sub-module, sat_narrow: ACC_BITS to bitsize clamp with an overflow flag. It is reusable by the pooling and activation stages.
- sat_add stays inline.

Test Plan:
- Basic 3x3 window:
  - Stimulus: start, num_terms=9, bias=0; 9 terms of 128 (1.0) on consecutive cycles.
  - Response: acc_out=1152 (9.0), out_valid a single pulse one edge after the 9th term, sat_flag=0.
- Bias and negatives with stalls:
  - Stimulus: bias=-64 (-0.5); num_terms=3; terms 256, -384, 64, with valid_in gaps of 2 cycles between them.
  - Response: acc_out=-128 (0xFF80 truncated to 14 bits, i.e. 0x3F80), sat_flag=0, busy high throughout.
- Output saturation:
  - Stimulus: num_terms=4, bias=0; terms 0x1FFF x4.
  - Response: acc_out=0x1FFF, sat_flag=1.
  - Repeat with 0x2000 x4: acc_out=0x2000, sat_flag=1.
- Zero-term window and ignored inputs:
  - Stimulus: num_terms=0, bias=300.
  - Response: acc_out=300, out_valid 2 edges after start.
  - Stimulus: start pulses during ACCUM, and valid_in in IDLE.
  - Response: no effect on count or sum.
- Reset mid-window:
  - Stimulus: rst low after 4 of 9 terms.
  - Response: immediately acc_out=0, out_valid=0, busy=0. A following full 9-term window yields the correct result with no residue.
- Integration with the multiplier:
  - Stimulus: chain the multiplier to this block; feed a=128, b=64 for 9 cycles.
  - Response: acc_out=576 (4.5).
